// File: rtl/elevator_pkg.sv
// Shared elevator definitions: shaft state encoding, position field widths and floor count.
package elevator_pkg;

  localparam int NUM_FLOORS = 4;
  localparam int FLOOR_W    = 2;
  localparam int OFFSET_W   = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_UP    = 2'd1,
    S_DOWN  = 2'd2,
    S_FAULT = 2'd3
  } shaft_state_t;

endpackage

// File: rtl/shaft_prescaler.sv
// Step prescaler: produces one tick every STEP_DIV enabled cycles.
// 'clear' restarts the count from zero in the same cycle, so that a freshly
// applied or reversed command still gets its first tick STEP_DIV cycles later.
module shaft_prescaler #(
  parameter int STEP_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_eff;

  // Effective count for this cycle and terminal-count detection.
  always_comb begin
    cnt_eff = clear ? '0 : cnt;
    tick    = enable && (cnt_eff == LAST);
  end

  // Count while enabled; wrap to zero on the tick or whenever disabled.
  always_ff @(posedge clk) begin
    if (rst || !enable || tick) cnt <= '0;
    else                        cnt <= cnt_eff + CNT_W'(1);
  end

endmodule

// File: rtl/elevator_shaft.sv
// Behavioural shaft/car plant: integrates motor commands into a floor/offset
// position and reports floor alignment back to the controller.
module elevator_shaft
  import elevator_pkg::*;
#(
  parameter int FLOORS   = NUM_FLOORS,
  parameter int TRAVEL   = 10,
  parameter int STEP_DIV = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                MotorUp,
  input  logic                MotorDown,
  input  logic                SensorMask,
  output logic                LevelTrans,
  output logic [FLOOR_W-1:0]  Floor,
  output logic [OFFSET_W-1:0] Offset,
  output logic                Moving,
  output logic                FloorArrive,
  output logic                OverTravel
);

  localparam logic [FLOOR_W-1:0]  TOP_FLOOR   = FLOOR_W'(FLOORS - 1);
  localparam logic [OFFSET_W-1:0] LAST_OFFSET = OFFSET_W'(TRAVEL - 1);

  shaft_state_t        state;
  logic                cmd_up;
  logic                cmd_down;
  logic                run_en;
  logic                restart;
  logic                step;
  logic                over;
  logic [FLOOR_W-1:0]  nxt_floor;
  logic [OFFSET_W-1:0] nxt_offset;

  // Command decode; a direction that differs from the current motion restarts the prescaler.
  always_comb begin
    cmd_up   = MotorUp & ~MotorDown;
    cmd_down = MotorDown & ~MotorUp;
    run_en   = (state != S_FAULT) && (cmd_up || cmd_down);
    restart  = (cmd_up && (state != S_UP)) || (cmd_down && (state != S_DOWN));
  end

  shaft_prescaler #(
    .STEP_DIV (STEP_DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .enable (run_en),
    .clear  (restart),
    .tick   (step)
  );

  // Next position for a step; stepping past either end flags over-travel instead.
  always_comb begin
    nxt_floor  = Floor;
    nxt_offset = Offset;
    over       = 1'b0;
    if (step) begin
      if (cmd_up) begin
        if (Floor == TOP_FLOOR && Offset == '0) begin
          over = 1'b1;
        end else if (Offset == LAST_OFFSET) begin
          nxt_offset = '0;
          nxt_floor  = Floor + FLOOR_W'(1);
        end else begin
          nxt_offset = Offset + OFFSET_W'(1);
        end
      end else begin
        if (Floor == '0 && Offset == '0) begin
          over = 1'b1;
        end else if (Offset == '0) begin
          nxt_floor  = Floor - FLOOR_W'(1);
          nxt_offset = LAST_OFFSET;
        end else begin
          nxt_offset = Offset - OFFSET_W'(1);
        end
      end
    end
  end

  // Motion FSM with registered position, arrival pulse and sticky fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      Floor       <= '0;
      Offset      <= '0;
      FloorArrive <= 1'b0;
      OverTravel  <= 1'b0;
    end else begin
      Floor       <= nxt_floor;
      Offset      <= nxt_offset;
      FloorArrive <= step && !over && (nxt_offset == '0);
      if (over) OverTravel <= 1'b1;
      if (state == S_FAULT || over) state <= S_FAULT;
      else if (cmd_up)              state <= S_UP;
      else if (cmd_down)            state <= S_DOWN;
      else                          state <= S_IDLE;
    end
  end

  // Alignment sensor and motion flag decoded from registered state.
  always_comb begin
    LevelTrans = (Offset == '0) && !SensorMask;
    Moving     = (state == S_UP) || (state == S_DOWN);
  end

endmodule

// File: tb/tb_elevator_shaft.sv
// Bench for elevator_shaft: absolute-position reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_elevator_shaft;

  localparam int FLOORS   = 4;
  localparam int TRAVEL   = 10;
  localparam int STEP_DIV = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       MotorUp;
  logic       MotorDown;
  logic       SensorMask;
  logic       LevelTrans;
  logic [1:0] Floor;
  logic [3:0] Offset;
  logic       Moving;
  logic       FloorArrive;
  logic       OverTravel;

  int n_checks = 0;
  int n_fail   = 0;
  int arrive_cnt = 0;

  // reference model: car height in steps above floor 0
  int m_pos = 0;
  int m_dir = 0;
  int m_cnt = 0;
  bit m_arrive = 1'b0;
  bit m_fault  = 1'b0;
  bit m_valid  = 1'b0;

  elevator_shaft #(
    .FLOORS   (FLOORS),
    .TRAVEL   (TRAVEL),
    .STEP_DIV (STEP_DIV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .MotorUp     (MotorUp),
    .MotorDown   (MotorDown),
    .SensorMask  (SensorMask),
    .LevelTrans  (LevelTrans),
    .Floor       (Floor),
    .Offset      (Offset),
    .Moving      (Moving),
    .FloorArrive (FloorArrive),
    .OverTravel  (OverTravel)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs presented at this edge.
  always @(posedge clk) begin
    int c;
    int np;
    if (rst) begin
      m_pos = 0; m_dir = 0; m_cnt = 0; m_arrive = 1'b0; m_fault = 1'b0; m_valid = 1'b1;
    end else if (m_fault) begin
      m_arrive = 1'b0;
    end else begin
      c = (MotorUp && !MotorDown) ? 1 : ((MotorDown && !MotorUp) ? -1 : 0);
      m_arrive = 1'b0;
      if (c == 0) begin
        m_cnt = 0;
        m_dir = 0;
      end else begin
        if (c != m_dir) m_cnt = 0;
        m_dir = c;
        m_cnt++;
        if (m_cnt == STEP_DIV) begin
          m_cnt = 0;
          np = m_pos + c;
          if (np < 0 || np > (FLOORS - 1) * TRAVEL) begin
            m_fault = 1'b1;
            m_dir   = 0;
          end else begin
            m_pos    = np;
            m_arrive = (np % TRAVEL == 0);
          end
        end
      end
    end
  end

  // Compare every output against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("floor",       32'(Floor),       32'(m_pos / TRAVEL));
      check("offset",      32'(Offset),      32'(m_pos % TRAVEL));
      check("level_trans", 32'(LevelTrans),  32'((m_pos % TRAVEL == 0) && !SensorMask));
      check("moving",      32'(Moving),      32'(m_dir != 0));
      check("floor_arrive",32'(FloorArrive), 32'(m_arrive));
      check("over_travel", 32'(OverTravel),  32'(m_fault));
      if (FloorArrive === 1'b1) arrive_cnt++;
    end
  end

  // Present inputs, let n rising edges pass, then settle just past the last edge.
  task automatic drive(input logic r, input logic up, input logic dn, input logic mask, input int n);
    rst = r; MotorUp = up; MotorDown = dn; SensorMask = mask;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; MotorUp = 1'b0; MotorDown = 1'b0; SensorMask = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_floor",  32'(Floor), 0);
    check("rst_offset", 32'(Offset), 0);
    check("rst_level",  32'(LevelTrans), 1);
    check("rst_moving", 32'(Moving), 0);
    check("rst_arrive", 32'(FloorArrive), 0);
    check("rst_over",   32'(OverTravel), 0);

    // 20 cycles up from floor 0: first step after 2 cycles, floor 1 after 20
    drive(0, 1, 0, 0, 1);
    check("up1_level", 32'(LevelTrans), 1);
    drive(0, 1, 0, 0, 1);
    check("up2_level", 32'(LevelTrans), 0);
    check("up2_offset", 32'(Offset), 1);
    arrive_cnt = 0;
    drive(0, 1, 0, 0, 18);
    check("up20_floor",  32'(Floor), 1);
    check("up20_offset", 32'(Offset), 0);
    check("up20_level",  32'(LevelTrans), 1);
    check("up20_arrive", 32'(FloorArrive), 1);
    check("up20_moving", 32'(Moving), 1);
    drive(0, 0, 0, 0, 1);
    check("up20_pulses", 32'(arrive_cnt), 1);
    check("up20_pulse_end", 32'(FloorArrive), 0);

    // reversal: two down cycles then two up cycles
    drive(0, 0, 1, 0, 2);
    check("rev_dn_floor",  32'(Floor), 0);
    check("rev_dn_offset", 32'(Offset), 9);
    check("rev_dn_level",  32'(LevelTrans), 0);
    drive(0, 1, 0, 0, 2);
    check("rev_up_floor",  32'(Floor), 1);
    check("rev_up_offset", 32'(Offset), 0);
    check("rev_up_arrive", 32'(FloorArrive), 1);

    // both commands mid-span hold position and clear the prescaler
    drive(0, 1, 0, 0, 8);
    check("mid_offset", 32'(Offset), 4);
    drive(0, 1, 1, 0, 10);
    check("both_floor",  32'(Floor), 1);
    check("both_offset", 32'(Offset), 4);
    check("both_moving", 32'(Moving), 0);
    drive(0, 1, 0, 0, 1);
    check("resume1_offset", 32'(Offset), 4);
    drive(0, 1, 0, 0, 1);
    check("resume2_offset", 32'(Offset), 5);

    // masked arrival at floor 2
    drive(0, 1, 0, 1, 10);
    check("mask_floor",  32'(Floor), 2);
    check("mask_offset", 32'(Offset), 0);
    check("mask_level",  32'(LevelTrans), 0);
    check("mask_arrive", 32'(FloorArrive), 1);
    drive(0, 0, 0, 0, 0);
    check("unmask_level", 32'(LevelTrans), 1);

    // over-travel at the top floor
    drive(0, 1, 0, 0, 20);
    check("top_floor",  32'(Floor), 3);
    check("top_offset", 32'(Offset), 0);
    check("top_over",   32'(OverTravel), 0);
    drive(0, 1, 0, 0, 2);
    check("ot_over",   32'(OverTravel), 1);
    check("ot_floor",  32'(Floor), 3);
    check("ot_offset", 32'(Offset), 0);
    check("ot_moving", 32'(Moving), 0);
    drive(0, 0, 1, 0, 6);
    check("ot_ign_floor",  32'(Floor), 3);
    check("ot_ign_offset", 32'(Offset), 0);
    check("ot_ign_over",   32'(OverTravel), 1);
    check("ot_ign_moving", 32'(Moving), 0);
    drive(1, 0, 0, 0, 1);
    check("ot_rst_floor", 32'(Floor), 0);
    check("ot_rst_over",  32'(OverTravel), 0);

    // over-travel at the bottom floor
    drive(0, 0, 1, 0, 2);
    check("bot_over",   32'(OverTravel), 1);
    check("bot_offset", 32'(Offset), 0);
    drive(1, 0, 0, 0, 1);

    // reset in the middle of upward motion
    drive(0, 1, 0, 0, 10);
    check("mv_offset", 32'(Offset), 5);
    check("mv_moving", 32'(Moving), 1);
    drive(1, 1, 0, 0, 1);
    check("mvrst_floor",  32'(Floor), 0);
    check("mvrst_offset", 32'(Offset), 0);
    check("mvrst_moving", 32'(Moving), 0);
    check("mvrst_level",  32'(LevelTrans), 1);
    drive(0, 0, 0, 0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/elevator_shaft.md
Name: elevator_shaft

Overview:
Behavioural shaft/car model that is the other end of the controller's level-sensor interface. It consumes the controller's motor up/down commands, moves a car position counter through a 4-floor shaft, and produces the LevelTrans floor-alignment signal the controller consumes. Used as the plant in closed-loop simulation and on-board demo builds in place of real hardware; also provides a sensor-mask input for fault-injection tests.

Parameters:
FLOORS, 4, number of floors (0..FLOORS-1)
TRAVEL, 10, position steps between adjacent floors (>=2)
STEP_DIV, 2, clock cycles per position step while the motor is on (>=1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
MotorUp  input  1  motor command: drive car up
MotorDown  input  1  motor command: drive car down
SensorMask  input  1  fault injection: forces LevelTrans low while 1
LevelTrans  output  1  level sensor: 1 when the car is aligned with a floor and not masked
Floor  output  2  floor at or below the car (0..FLOORS-1)
Offset  output  4  step offset above Floor (0..TRAVEL-1)
Moving  output  1  1 while in state UP or DOWN
FloorArrive  output  1  one-cycle pulse on the cycle after a step lands on Offset==0
OverTravel  output  1  sticky fault: motion commanded past the top or bottom floor

Behaviour:
- Reset (rst=1 at a clk edge, any state, mid-motion included): state IDLE, Floor=0, Offset=0, prescaler=0, FloorArrive=0, OverTravel=0. Therefore LevelTrans=~SensorMask and Moving=0.
- Command decode: cmd=UP if MotorUp&~MotorDown; DOWN if MotorDown&~MotorUp; otherwise HOLD (both or neither asserted).
- States: IDLE, UP, DOWN, FAULT. Next state is UP/DOWN/IDLE per cmd, except that FAULT is absorbing until rst.
- Prescaler: counts 0..STEP_DIV-1 while state is UP or DOWN and cmd equals the current direction. It clears to 0 when cmd is HOLD or the direction changes. A step occurs on the cycle the prescaler equals STEP_DIV-1. The first step comes STEP_DIV cycles after a command is first applied.
- Up step: if Floor==FLOORS-1 and Offset==0, go to FAULT, set OverTravel, and leave the position unchanged. Otherwise Offset+1; when it reaches TRAVEL, set Offset=0 and Floor+1.
- Down step: if Floor==0 and Offset==0, go to FAULT, set OverTravel, and leave the position unchanged. Otherwise, if Offset==0, set Floor-1 and Offset=TRAVEL-1; else Offset-1.
- Reversal between floors is legal. The car retraces and re-arrives at the floor below or above.
- LevelTrans = (Offset==0) & ~SensorMask. It is combinational from registered position and has no extra latency beyond the step register.
- FloorArrive is registered. It is 1 for exactly one cycle after a step that results in Offset==0. It is not asserted at reset, and it is still asserted when SensorMask=1.
- FAULT state: position frozen, Moving=0, OverTravel=1. Commands are ignored.
- Registered outputs: Floor, Offset, FloorArrive, OverTravel. Moving is decoded from state.

Decomposition:
- Shared package elevator_pkg holds:
  - state encoding constants S_IDLE, S_UP, S_DOWN, S_FAULT;
  - FLOOR_W=2;
  - OFFSET_W=4;
  - the floor count constant, shared with the Elevator controller and its request encoders.
- One natural sub-module: shaft_prescaler (clear, enable, STEP_DIV terminal-count pulse).
- Position/FSM logic stays in elevator_shaft.

Test Plan:
- Defaults. rst, then MotorUp=1 for 20 cycles -> LevelTrans drops after cycle 2; after cycle 20 Floor=1, Offset=0, LevelTrans=1, one FloorArrive pulse, Moving=1.
- From Floor=1 Offset=0, MotorDown=1 for 2 cycles -> Floor=0, Offset=9, LevelTrans=0. Then MotorUp=1 for 2 cycles -> Floor=1, Offset=0, FloorArrive pulse (reversal).
- Drive MotorUp until Floor=3 Offset=0, then 2 more up cycles -> OverTravel=1, position stays 3/0, Moving=0. Later MotorDown is ignored. rst clears everything to 0/0.
- MotorUp=MotorDown=1 for 10 cycles mid-span (Offset=4) -> position unchanged, Moving=0, prescaler cleared. Releasing MotorDown gives the next step exactly 2 cycles later.
- SensorMask=1 while arriving at Floor=2 -> LevelTrans stays 0, FloorArrive still pulses. Dropping the mask -> LevelTrans=1 the same cycle.
- rst asserted at Offset=5 while moving up -> next cycle Floor=0, Offset=0, state IDLE, LevelTrans=1.
